// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Latency: none (types/functions only). Backpressure: not applicable.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Saturating clamp used for parallel load; 32 bits covers any legal WIDTH.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-count and wrap generation for one enabled step.
// Latency: 0 cycles. Backpressure: none. COUNTER_SATURATE_EN selects saturate over wrap.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_VALUE = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             enable,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  // One guard bit so the bound compare never depends on 2^WIDTH rollover.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VALUE);

  logic [WIDTH:0] cnt_ext;

  assign cnt_ext = {1'b0, count};

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (enable) begin
      if (up == DIR_DOWN) begin
        if (cnt_ext == '0) begin
          next_wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next_count = '0;
`else
          next_count = WIDTH'(MAX_EXT);
`endif
        end else begin
          next_count = WIDTH'(cnt_ext - 1'b1);
        end
      end else begin
        if (cnt_ext >= MAX_EXT) begin
          next_wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next_count = WIDTH'(MAX_EXT);
`else
          next_count = '0;
`endif
        end else begin
          next_count = WIDTH'(cnt_ext + 1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_param_1clk_posedge_sync_reset.sv
// Up/down counter with modulus, clamped load, wrap pulse and sticky wrap flag.
// Latency: 1 cycle (at_terminal is combinational). Backpressure: none. Option: COUNTER_SATURATE_EN.
module counter_updown_param_1clk_posedge_sync_reset
  import counter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MAX_VALUE   = 2**WIDTH - 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_sticky,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_terminal,
  output logic             wrap_sticky
);

  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;
  logic [WIDTH-1:0] load_clamped;

  counter_next_value #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .count      (count_q),
    .up         (up),
    .enable     (enable),
    .next_count (step_count),
    .next_wrap  (step_wrap)
  );

  assign load_clamped = WIDTH'(clamp_to_max(32'(load_value), 32'(MAX_VALUE)));

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      count_d = step_count;
      wrap_d  = step_wrap;
    end
    // A new wrap beats a coincident clear.
    sticky_d = wrap_d ? 1'b1 : (clear_sticky ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      count_q  <= RESET_CNT;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign count       = count_q;
  assign wrap        = wrap_q;
  assign wrap_sticky = sticky_q;
  assign at_terminal = (up == DIR_UP) ? (count_q == MAX_CNT) : (count_q == '0);

endmodule

// File: tb/tb_counter_updown_param_1clk_posedge_sync_reset.sv
// Scoreboard bench for the up/down counter at WIDTH=4, MAX_VALUE=9, RESET_VALUE=0.
// Define COUNTER_SATURATE_EN to run the saturating scenario instead of the wrap scenarios.
module tb_counter_updown_param_1clk_posedge_sync_reset;

  logic       clock0 = 1'b0;
  logic       reset, enable, up, load, clear_sticky;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       wrap, at_terminal, wrap_sticky;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] cnt;
    logic       wr;
    logic       st;
    logic       term;
  } exp_t;

  typedef struct {
    logic       rst, ld, en, u, clr;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       wr, st, term;
  } step_t;

  exp_t sb_q[$];

  counter_updown_param_1clk_posedge_sync_reset #(
    .WIDTH       (4),
    .MAX_VALUE   (9),
    .RESET_VALUE (0)
  ) dut (
    .clock0       (clock0),
    .reset        (reset),
    .enable       (enable),
    .up           (up),
    .load         (load),
    .load_value   (load_value),
    .clear_sticky (clear_sticky),
    .count        (count),
    .wrap         (wrap),
    .at_terminal  (at_terminal),
    .wrap_sticky  (wrap_sticky)
  );

  always #5 clock0 = ~clock0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_and_push(input step_t s);
    exp_t e;
    reset = s.rst; load = s.ld; enable = s.en; up = s.u;
    clear_sticky = s.clr; load_value = s.lv;
    e.cnt = s.cnt; e.wr = s.wr; e.st = s.st; e.term = s.term;
    sb_q.push_back(e);
    @(posedge clock0);
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    exp_t  e;
    s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    drive_and_push(s);
    e = sb_q.pop_front();
    checks++; if (count !== e.cnt) begin fails++; $display("FAIL reset count: got %0d want %0d", count, e.cnt); end
    checks++; if (wrap !== e.wr) begin fails++; $display("FAIL reset wrap: got %0b want %0b", wrap, e.wr); end
    checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL reset sticky: got %0b want %0b", wrap_sticky, e.st); end
    checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL reset at_terminal: got %0b want %0b", at_terminal, e.term); end
  endtask

  task automatic test_count_up();
    step_t s;
    exp_t  e;
    for (int i = 1; i <= 12; i++) begin
      s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 10), (i == 10), (i >= 10), ((i % 10) == 9)};
      drive_and_push(s);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL count_up[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL count_up[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL count_up[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL count_up[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_load_down();
    step_t st [8];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0};
    st[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0};
    st[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0};
    st[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    st[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    st[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0};
    st[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL load_down[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL load_down[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL load_down[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL load_down[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_load_clamp();
    step_t st [2];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 4'd9, 1'b0, 1'b1, 1'b1};
    // Enabled up at MAX would wrap, but load has priority and suppresses wrap.
    st[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL load_clamp[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL load_clamp[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL load_clamp[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL load_clamp[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_sticky_clear();
    step_t st [5];
    exp_t  e;
    st[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    st[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
    st[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    st[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL sticky[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL sticky[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL sticky[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL sticky[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_back_to_back();
    step_t st [5];
    exp_t  e;
    st[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    st[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0};
    st[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
    st[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL back_to_back[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL back_to_back[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL back_to_back[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL back_to_back[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_reset_mid();
    step_t st [4];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0};
    st[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    st[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1};
    st[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL reset_mid[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL reset_mid[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL reset_mid[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL reset_mid[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  task automatic test_saturate();
    step_t st [7];
    exp_t  e;
    st[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    st[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1};
    st[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1};
    st[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1};
    st[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    st[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive_and_push(st[i]);
      e = sb_q.pop_front();
      checks++; if (count !== e.cnt) begin fails++; $display("FAIL saturate[%0d] count: got %0d want %0d", i, count, e.cnt); end
      checks++; if (wrap !== e.wr) begin fails++; $display("FAIL saturate[%0d] wrap: got %0b want %0b", i, wrap, e.wr); end
      checks++; if (wrap_sticky !== e.st) begin fails++; $display("FAIL saturate[%0d] sticky: got %0b want %0b", i, wrap_sticky, e.st); end
      checks++; if (at_terminal !== e.term) begin fails++; $display("FAIL saturate[%0d] at_terminal: got %0b want %0b", i, at_terminal, e.term); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
    clear_sticky = 1'b0; load_value = 4'd0;
    @(negedge clock0);
    test_reset();
`ifdef COUNTER_SATURATE_EN
    test_saturate();
`else
    test_count_up();
    test_load_down();
    test_load_clamp();
    test_sticky_clear();
    test_back_to_back();
    test_reset_mid();
`endif
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/counter_updown_param_1clk_posedge_sync_reset.md
# counter_updown_param_1clk_posedge_sync_reset

Parametrised up/down counter with configurable width and modulus, synchronous parallel load, count enable, and wrap/terminal-count reporting. It generalises the fixed 16-bit up-counter family in the simple_registers/counters suite. It serves as a reusable timer/index primitive and as a benchmark of moderate control complexity: priority muxing, modulus compare, and sticky flags.

## Interface
- WIDTH, 16, counter width in bits (≥2)
- MAX_VALUE, 2**WIDTH-1, highest legal count; the count range is 0..MAX_VALUE
- RESET_VALUE, 0, count value after reset (must be ≤ MAX_VALUE)

- clock0  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  count enable
- up  input  1  1 = count up, 0 = count down
- load  input  1  synchronous parallel load strobe
- load_value  input  WIDTH  value for load
- clear_sticky  input  1  clears wrap_sticky
- count  output  WIDTH  current count (registered)
- wrap  output  1  one-cycle pulse: last update wrapped or saturated
- at_terminal  output  1  combinational: count == MAX_VALUE when up=1, count == 0 when up=0
- wrap_sticky  output  1  set by any wrap event; held until cleared

## Operation
- Reset values: count=RESET_VALUE, wrap=0, wrap_sticky=0. Reset overrides all other inputs.
- Per-edge priority: reset > load > enable > hold.
- Load: count ← load_value. If load_value > MAX_VALUE, count ← MAX_VALUE. Load never asserts wrap.
- Enable with up=1: count+1; at MAX_VALUE the next value is 0 and wrap=1.
- Enable with up=0: count-1; at 0 the next value is MAX_VALUE and wrap=1.
- enable=0 and load=0: count holds; wrap=0.
- Arithmetic is WIDTH+1 bits internally. The compare against MAX_VALUE uses the exact value, with no reliance on natural 2^WIDTH rollover.
- wrap_sticky: set when wrap is set. Otherwise cleared by clear_sticky. If set and clear occur in the same cycle, set wins.
- Changing direction takes effect on the next enabled edge; there is no penalty cycle.
- There is no state machine beyond the count register and two flags.

## Timing
- count, wrap, and wrap_sticky are registered and update on the clock0 edge that samples the controls. Latency from input to output is 1 cycle.
- at_terminal is combinational from count and up. It is valid in the same cycle, so a producer can gate enable without an extra cycle.
- wrap is high for exactly the cycle after the wrapping edge. Continuous counting with MAX_VALUE=0 or 1 may hold wrap high on consecutive cycles; this is legal.
- Reset asserted mid-count returns to RESET_VALUE on that edge and clears both flags, including a coincident wrap.

## Configuration
- COUNTER_SATURATE_EN
  - Defined: the counter saturates instead of wrapping. Up at MAX_VALUE holds MAX_VALUE; down at 0 holds 0. wrap pulses on each enabled edge attempted at a bound, and wrap_sticky records it.
  - Undefined: modulo wrap-around as described in Operation.
  - Load, reset, and all timing are identical in both builds.

## Structure
- Shared package counter_pkg holds:
  - the direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0
  - a function computing clamp(load_value, MAX_VALUE)
- One sub-module, counter_next_value, is combinational. It takes count, up, enable, and MAX_VALUE, and returns the next count and a wrap bit. The saturate/wrap choice is made under the macro.
- The top level holds the registers, the priority mux, and the sticky logic.

## Test plan
All scenarios use WIDTH=4, MAX_VALUE=9, RESET_VALUE=0.
- Reset, then 12 enabled up cycles → count 1..9, 0, 1, 2. wrap is high only in the cycle count shows 0. wrap_sticky=1 from then on.
- Load 5, then down for 7 cycles → 4, 3, 2, 1, 0, 9, 8. wrap is high with count=9. at_terminal is high while count=0 and up=0.
- Load 13 → count=9 (clamped) and wrap=0. Same cycle load=1, enable=1, load_value=3 → count=3 (load wins).
- Assert wrap and clear_sticky in the same cycle → wrap_sticky stays 1. Clear alone next cycle → 0.
- Reset asserted while count=7 with enable=1 → next count=0, wrap=0, wrap_sticky=0.
- With COUNTER_SATURATE_EN defined: up from 8 for 3 cycles → 9, 9, 9, with wrap high on the 2nd and 3rd cycles. Down from 0 → holds 0, wrap=1.
